fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the instruction fetch path: FSM state encoding, default widths,
// and the instruction field layout used by decode.
package cpu_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Field layout of a 16-bit instruction word: rd [12:9], rs2 [8:5], rs1 [4:1], op [0].
  typedef struct packed {
    logic [2:0] rsvd;
    logic [3:0] rd;
    logic [3:0] rs2;
    logic [3:0] rs1;
    logic       op;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [15:0] word);
    return instr_fields_t'(word);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-path bundle: command-memory request/ack on one side, queue head to decode
// on the other. The fetch unit is the master.
interface fetch_queue_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              en;
  logic              flush;
  logic [ADDR_W-1:0] flush_adr;
  logic              in_cmd_mem;
  logic [ADDR_W-1:0] adr_cmd;
  logic [DATA_W-1:0] cmd;
  logic              out_cmd_mem;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    input  en, flush, flush_adr, cmd, out_cmd_mem, instr_ready,
    output in_cmd_mem, adr_cmd, instr_valid, instr, instr_pc
  );

  modport slave (
    output en, flush, flush_adr, cmd, out_cmd_mem, instr_ready,
    input  in_cmd_mem, adr_cmd, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction queue storage with a registered head. The head register is loaded
// directly from push_data when the queue would otherwise be empty, so a push is
// visible at the head one cycle later.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, tail, head_nxt;
  logic [CNT_W-1:0] cnt, cnt_after_pop, cnt_nxt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_nxt      = do_pop ? head + 1'b1 : head;
  assign cnt_after_pop = do_pop ? cnt - 1'b1 : cnt;
  assign cnt_nxt       = do_push ? cnt_after_pop + 1'b1 : cnt_after_pop;

  always_ff @(posedge clk) begin
    if (!rst && !clr && do_push) begin
      mem[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (clr) begin
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      head_valid <= 1'b0;
    end else begin
      head       <= head_nxt;
      cnt        <= cnt_nxt;
      head_valid <= (cnt_nxt != '0);
      if (do_push) begin
        tail <= tail + 1'b1;
      end
      // The entry just pushed becomes the head when nothing older survives this cycle.
      if (cnt_after_pop == '0) begin
        if (do_push) begin
          head_data <= push_data;
        end
      end else begin
        head_data <= mem[head_nxt];
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues one command-memory read at a time and queues the
// returned instructions with their fetch address for decode.
//
// state | meaning
// IDLE  | no request outstanding; may issue when enabled and a slot is free
// REQ   | request outstanding; its data will be queued on ack
// DROP  | request outstanding but flushed; its data is discarded on ack
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] adr_q;
  logic              req_q;

  logic                     push, pop;
  logic                     head_valid;
  logic [DATA_W+ADDR_W-1:0] head_data;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_empty;
  logic                     unused_fifo_full;

  // Only REQ can push, and a flush in the same cycle discards the returning data.
  assign push = (state == REQ) && bus.out_cmd_mem && !bus.flush;
  assign pop  = !fifo_empty && bus.instr_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      adr_q <= '0;
      req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            pc <= bus.flush_adr;
          end else if (bus.en && (fifo_count < DEPTH_CNT)) begin
            req_q <= 1'b1;
            adr_q <= pc;
            state <= REQ;
          end
        end
        REQ: begin
          if (bus.out_cmd_mem) begin
            req_q <= 1'b0;
            state <= IDLE;
            pc    <= bus.flush ? bus.flush_adr : adr_q + 1'b1;
          end else if (bus.flush) begin
            pc    <= bus.flush_adr;
            state <= DROP;
          end
        end
        DROP: begin
          if (bus.flush) begin
            pc <= bus.flush_adr;
          end
          if (bus.out_cmd_mem) begin
            req_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.flush),
    .push       (push),
    .push_data  ({bus.cmd, adr_q}),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (fifo_count),
    .full       (unused_fifo_full),
    .empty      (fifo_empty)
  );

  assign bus.in_cmd_mem  = req_q;
  assign bus.adr_cmd     = adr_q;
  assign bus.instr_valid = head_valid;
  assign {bus.instr, bus.instr_pc} = head_data;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based model of the fetch rules.
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  // reference model: queue contents, outstanding request, PC
  entry_t            q[$];
  bit                m_req, m_drop;
  logic [ADDR_W-1:0] m_adr, m_pc;
  int unsigned       m_issue;

  // memory responder state and stimulus knobs
  int unsigned seen_issue;
  int          wait_left;
  int          p_en, p_ready, p_flush_pm, p_spur, p_rst_pm, dmin, dmax;
  bit          fixed_cmd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit     pop, push;
    entry_t e;
    push = 1'b0;
    e    = '0;
    if (rst) begin
      q.delete();
      m_req  = 1'b0;
      m_drop = 1'b0;
      m_adr  = '0;
      m_pc   = '0;
      return;
    end
    pop = (q.size() > 0) && bus.instr_ready && !bus.flush;
    if (m_req) begin
      if (bus.out_cmd_mem) begin
        if (bus.flush) begin
          m_pc = bus.flush_adr;
        end else if (!m_drop) begin
          push = 1'b1;
          e.data = bus.cmd;
          e.pc   = m_adr;
          m_pc   = m_adr + 1'b1;
        end
        m_req  = 1'b0;
        m_drop = 1'b0;
      end else if (bus.flush) begin
        m_pc   = bus.flush_adr;
        m_drop = 1'b1;
      end
    end else if (bus.flush) begin
      m_pc = bus.flush_adr;
    end else if (bus.en && (q.size() < DEPTH)) begin
      m_req = 1'b1;
      m_adr = m_pc;
      m_issue++;
    end
    if (bus.flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
  endtask

  task automatic check();
    chk("in_cmd_mem", bus.in_cmd_mem, m_req);
    if (m_req) chk("adr_cmd", bus.adr_cmd, m_adr);
    chk("instr_valid", bus.instr_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("instr", bus.instr, q[0].data);
      chk("instr_pc", bus.instr_pc, q[0].pc);
    end
  endtask

  task automatic gen_inputs();
    rst             = ($urandom_range(999) < p_rst_pm);
    bus.en          = ($urandom_range(99) < p_en);
    bus.instr_ready = ($urandom_range(99) < p_ready);
    bus.flush       = ($urandom_range(999) < p_flush_pm);
    bus.flush_adr   = ADDR_W'($urandom);
    if (m_req) begin
      if (seen_issue != m_issue) begin
        seen_issue = m_issue;
        wait_left  = int'($urandom_range(dmax, dmin)) - 1;
      end
      if (wait_left <= 0) begin
        bus.out_cmd_mem = 1'b1;
      end else begin
        bus.out_cmd_mem = 1'b0;
        wait_left--;
      end
    end else begin
      bus.out_cmd_mem = ($urandom_range(99) < p_spur);
    end
    bus.cmd = fixed_cmd ? DATA_W'(16'h1000 + m_adr) : DATA_W'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check();
    gen_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_in_cmd_mem", bus.in_cmd_mem, 0);
    chk("rst_adr_cmd", bus.adr_cmd, 0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
  endtask

  task automatic set_knobs(input int en_p, input int rdy_p, input int dlo, input int dhi);
    p_en = en_p; p_ready = rdy_p; dmin = dlo; dmax = dhi;
    p_flush_pm = 0; p_spur = 0; p_rst_pm = 0; fixed_cmd = 1'b1;
  endtask

  initial begin
    int got, t6, n_ack, first_adr, nr, saw_old, new_adr;
    bit prev, dropped;
    int adrs[2];

    rst = 1'b1;
    bus.en = 1'b0; bus.flush = 1'b0; bus.flush_adr = '0;
    bus.cmd = '0; bus.out_cmd_mem = 1'b0; bus.instr_ready = 1'b0;
    m_req = 1'b0; m_drop = 1'b0; m_adr = '0; m_pc = '0; m_issue = 0;
    seen_issue = 0; wait_left = 0;

    // streaming with single-cycle ack: one instruction every two cycles
    set_knobs(100, 100, 1, 1);
    do_reset();
    got = 0; t6 = 0;
    for (int i = 1; i <= 40 && got < 6; i++) begin
      tick();
      if (bus.instr_valid && bus.instr_ready) begin
        chk("stream_instr", bus.instr, 32'h1000 + got);
        chk("stream_pc", bus.instr_pc, got % 16);
        got++;
        if (got == 6) t6 = i;
      end
    end
    chk("stream_count", got, 6);
    chk("stream_cycles", t6, 12);

    // decode stalled: exactly DEPTH fetches, then drain in order and resume at 4
    set_knobs(100, 0, 1, 1);
    do_reset();
    n_ack = 0;
    repeat (20) begin
      tick();
      if (bus.in_cmd_mem && bus.out_cmd_mem) n_ack++;
    end
    chk("full_acks", n_ack, 4);
    chk("full_no_req", bus.in_cmd_mem, 0);
    chk("full_valid", bus.instr_valid, 1);
    chk("full_head", bus.instr, 16'h1000);
    p_ready = 100;
    bus.instr_ready = 1'b1;
    got = 0; first_adr = -1;
    for (int i = 0; i < 60 && got < 8; i++) begin
      if (bus.instr_valid && bus.instr_ready) begin
        chk("drain_instr", bus.instr, 32'h1000 + got);
        chk("drain_pc", bus.instr_pc, got);
        got++;
      end
      if (first_adr < 0 && bus.in_cmd_mem) first_adr = int'(bus.adr_cmd);
      tick();
    end
    chk("drain_count", got, 8);
    chk("resume_adr", first_adr, 4);

    // PC wrap from 15 to 0
    set_knobs(0, 100, 1, 1);
    do_reset();
    bus.flush = 1'b1;
    bus.flush_adr = 4'd15;
    tick();
    p_en = 100;
    bus.en = 1'b1;
    nr = 0; prev = 1'b0;
    adrs[0] = -1; adrs[1] = -1;
    for (int i = 0; i < 30 && nr < 2; i++) begin
      if (bus.in_cmd_mem && !prev) begin
        adrs[nr] = int'(bus.adr_cmd);
        nr++;
      end
      prev = bus.in_cmd_mem;
      tick();
    end
    chk("wrap_first", adrs[0], 15);
    chk("wrap_second", adrs[1], 0);

    // flush while a request waits on a slow ack
    set_knobs(100, 100, 3, 3);
    do_reset();
    for (int i = 0; i < 10 && !bus.in_cmd_mem; i++) tick();
    chk("drop_req_up", bus.in_cmd_mem, 1);
    bus.flush = 1'b1;
    bus.flush_adr = 4'd9;
    tick();
    chk("drop_hold_req", bus.in_cmd_mem, 1);
    chk("drop_hold_adr", bus.adr_cmd, 0);
    saw_old = 0; dropped = 1'b0; new_adr = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.instr_valid && bus.instr == 16'h1000) saw_old++;
      if (!bus.in_cmd_mem) dropped = 1'b1;
      if (dropped && bus.in_cmd_mem && new_adr < 0) new_adr = int'(bus.adr_cmd);
    end
    chk("drop_discarded", saw_old, 0);
    chk("drop_new_adr", new_adr, 9);

    // reset in the middle of an outstanding request
    set_knobs(100, 0, 3, 3);
    do_reset();
    for (int i = 0; i < 40 && !(bus.in_cmd_mem && bus.instr_valid); i++) tick();
    chk("midrst_busy", bus.in_cmd_mem && bus.instr_valid, 1);
    do_reset();
    new_adr = -1;
    for (int i = 0; i < 10 && new_adr < 0; i++) begin
      if (bus.in_cmd_mem) new_adr = int'(bus.adr_cmd);
      else tick();
    end
    chk("midrst_first_adr", new_adr, 0);

    // randomized traffic: variable latency, stalls, flushes, stray acks, resets
    set_knobs(80, 60, 1, 4);
    p_flush_pm = 30; p_spur = 30; p_rst_pm = 5; fixed_cmd = 1'b0;
    repeat (4000) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
